// File: rtl/l23buf_line_counters.sv
// l23buf_line_counters
// ---------------------------------------------------------------------------
// Pointer and occupancy block for the L2/L3 line buffer. The dual-port BRAM
// is treated as a ring of NUM_LINES lines of up to 2^CHAR_W words each. The
// write-side and read-side FSMs report word/line events through one-cycle
// strobes; this block turns them into BRAM addresses and flow-control flags.
// A line only becomes visible to the reader when it is committed. Aborted or
// oversize lines are dropped without consuming a slot.
//
// Optional feature macro: L23BUF_STATS_EN adds saturating line statistics.
//
// Ports:
//   clk                    clock
//   rst                    synchronous active-high reset
//   wr_char_incr_i         write FSM: word accepted, not last
//   wr_newline_i           write FSM: last word accepted, line good
//   wr_restart_line_i      write FSM: last word accepted, line aborted
//   rd_char_incr_i         read FSM: word consumed, not last
//   rd_newline_i           read FSM: last word of line consumed
//   wr_greenflag_o         at least one free line slot
//   rd_greenflag_o         at least one committed line
//   rd_lastflag_o          rd_addr_o points at last word of current read line
//   wr_addr_o              {wr_line, wr_char} to BRAM port A
//   rd_addr_o              {rd_line, rd_char} to BRAM port B
//   line_count_o           committed, unread lines (0..NUM_LINES)
//   wr_overflow_o          current write line exceeded 2^CHAR_W words
//   stat_lines_committed_o (L23BUF_STATS_EN) successful commits, saturating
//   stat_lines_dropped_o   (L23BUF_STATS_EN) dropped lines, saturating
// ---------------------------------------------------------------------------
module l23buf_line_counters #(
    parameter int LINE_W = 3,
    parameter int CHAR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_char_incr_i,
    input  logic                     wr_newline_i,
    input  logic                     wr_restart_line_i,
    input  logic                     rd_char_incr_i,
    input  logic                     rd_newline_i,
    output logic                     wr_greenflag_o,
    output logic                     rd_greenflag_o,
    output logic                     rd_lastflag_o,
    output logic [LINE_W+CHAR_W-1:0] wr_addr_o,
    output logic [LINE_W+CHAR_W-1:0] rd_addr_o,
    output logic [LINE_W:0]          line_count_o,
    output logic                     wr_overflow_o
`ifdef L23BUF_STATS_EN
    ,
    output logic [15:0]              stat_lines_committed_o,
    output logic [15:0]              stat_lines_dropped_o
`endif
);

    localparam int                 NUM_LINES  = 2 ** LINE_W;
    localparam logic [CHAR_W-1:0]  CHAR_MAX   = {CHAR_W{1'b1}};
    localparam logic [LINE_W:0]    COUNT_FULL = (LINE_W + 1)'(NUM_LINES);
    localparam logic [LINE_W:0]    COUNT_ZERO = {(LINE_W + 1){1'b0}};

    logic [LINE_W-1:0] wr_line_q, wr_line_d;
    logic [CHAR_W-1:0] wr_char_q, wr_char_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic [CHAR_W-1:0] rd_char_q, rd_char_d;
    logic [LINE_W:0]   line_count_q, line_count_d;
    logic              wr_overflow_q, wr_overflow_d;
    // Index of the last word of each committed line.
    logic [CHAR_W-1:0] len_q [NUM_LINES];
    logic [CHAR_W-1:0] len_d [NUM_LINES];

    logic full_s;
    logic rd_valid_s;
    logic commit_s;
    logic drop_s;
    logic rd_dec_s;

`ifdef L23BUF_STATS_EN
    logic [15:0] stat_committed_q, stat_committed_d;
    logic [15:0] stat_dropped_q, stat_dropped_d;
`endif

    // Event qualification shared by the next-state logic.
    always_comb begin
        full_s     = (line_count_q == COUNT_FULL);
        rd_valid_s = (line_count_q != COUNT_ZERO);
        // A newline on a full ring cannot legally happen; it is ignored.
        commit_s   = wr_newline_i && !wr_overflow_q && !full_s;
        // An oversize line that reaches its last word is dropped like an abort.
        drop_s     = wr_restart_line_i || (wr_newline_i && wr_overflow_q);
        // Reads with nothing committed are protocol errors and do nothing.
        rd_dec_s   = rd_newline_i && rd_valid_s;
    end

    // Write-side pointer, overflow and line-length next state.
    always_comb begin
        wr_line_d     = wr_line_q;
        wr_char_d     = wr_char_q;
        wr_overflow_d = wr_overflow_q;
        len_d         = len_q;
        if (wr_char_incr_i) begin
            if (wr_char_q != CHAR_MAX) begin
                wr_char_d = wr_char_q + CHAR_W'(1);
            end else begin
                // Hold at the last address; further words overwrite it.
                wr_overflow_d = 1'b1;
            end
        end else if (commit_s) begin
            len_d[wr_line_q] = wr_char_q;
            wr_line_d        = wr_line_q + LINE_W'(1);
            wr_char_d        = {CHAR_W{1'b0}};
        end else if (drop_s) begin
            wr_char_d     = {CHAR_W{1'b0}};
            wr_overflow_d = 1'b0;
        end else begin
            wr_line_d = wr_line_q;
        end
    end

    // Read-side pointer next state.
    always_comb begin
        rd_line_d = rd_line_q;
        rd_char_d = rd_char_q;
        if (rd_dec_s) begin
            rd_line_d = rd_line_q + LINE_W'(1);
            rd_char_d = {CHAR_W{1'b0}};
        end else if (rd_char_incr_i && rd_valid_s) begin
            rd_char_d = rd_char_q + CHAR_W'(1);
        end else begin
            rd_char_d = rd_char_q;
        end
    end

    // Occupancy next state; simultaneous commit and read-out cancel.
    always_comb begin
        line_count_d = line_count_q;
        case ({commit_s, rd_dec_s})
            2'b10:   line_count_d = line_count_q + (LINE_W + 1)'(1);
            2'b01:   line_count_d = line_count_q - (LINE_W + 1)'(1);
            default: line_count_d = line_count_q;
        endcase
    end

`ifdef L23BUF_STATS_EN
    // Saturating line statistics.
    always_comb begin
        stat_committed_d = stat_committed_q;
        stat_dropped_d   = stat_dropped_q;
        if (commit_s && (stat_committed_q != 16'hFFFF)) begin
            stat_committed_d = stat_committed_q + 16'd1;
        end else begin
            stat_committed_d = stat_committed_q;
        end
        if (drop_s && (stat_dropped_q != 16'hFFFF)) begin
            stat_dropped_d = stat_dropped_q + 16'd1;
        end else begin
            stat_dropped_d = stat_dropped_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_committed_q <= 16'd0;
            stat_dropped_q   <= 16'd0;
        end else begin
            stat_committed_q <= stat_committed_d;
            stat_dropped_q   <= stat_dropped_d;
        end
    end

    assign stat_lines_committed_o = stat_committed_q;
    assign stat_lines_dropped_o   = stat_dropped_q;
`endif

    // State registers; reset discards any partial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_line_q     <= {LINE_W{1'b0}};
            wr_char_q     <= {CHAR_W{1'b0}};
            rd_line_q     <= {LINE_W{1'b0}};
            rd_char_q     <= {CHAR_W{1'b0}};
            line_count_q  <= COUNT_ZERO;
            wr_overflow_q <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                len_q[i] <= {CHAR_W{1'b0}};
            end
        end else begin
            wr_line_q     <= wr_line_d;
            wr_char_q     <= wr_char_d;
            rd_line_q     <= rd_line_d;
            rd_char_q     <= rd_char_d;
            line_count_q  <= line_count_d;
            wr_overflow_q <= wr_overflow_d;
            for (int i = 0; i < NUM_LINES; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    assign wr_greenflag_o = (line_count_q != COUNT_FULL);
    assign rd_greenflag_o = (line_count_q != COUNT_ZERO);
    assign rd_lastflag_o  = (rd_char_q == len_q[rd_line_q]);
    assign wr_addr_o      = {wr_line_q, wr_char_q};
    assign rd_addr_o      = {rd_line_q, rd_char_q};
    assign line_count_o   = line_count_q;
    assign wr_overflow_o  = wr_overflow_q;

endmodule
